stopwatch_controller: RTL and testbench

STOPWATCH_CONTROLLER -- requirements
Module: stopwatch_controller

---
 rtl/stopwatch_pkg.sv | 24 ++
 rtl/button_conditioner.sv | 61 ++++++
 rtl/stopwatch_controller.sv | 158 +++++++++++++++
 tb/tb_stopwatch_controller.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller.
//   state_t          : FSM state encoding (IDLE=00, RUN=01, PAUSE=10, ADJUST=11)
//   DEF_*            : default timing parameters for a 100 MHz clock
//   adjust_blank()   : digit blank pattern for the field being adjusted
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSE  = 2'b10,
    ADJUST = 2'b11
  } state_t;

  localparam int DEF_TICK_DIV        = 100_000_000;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_BLINK_DIV       = 50_000_000;
  localparam int DEF_SCAN_DIV        = 200_000;

  // bit0 = seconds units ... bit3 = minutes tens
  function automatic logic [3:0] adjust_blank(input logic sel);
    return sel ? 4'b1100 : 4'b0011;
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Conditions one raw mechanical button into a single-cycle press pulse.
// Ports:
//   clk    : system clock
//   reset  : asynchronous active-high reset
//   raw    : raw asynchronous button level
//   pulse  : one-cycle pulse when a debounced rising level is accepted
// The raw input passes a 2-flop synchronizer; a new level is accepted only
// after it has differed from the accepted level for DEBOUNCE_CYCLES
// consecutive cycles, so shorter glitches never produce a pulse.
module button_conditioner
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_reg;
  logic             level_reg, level_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             pulse_reg, pulse_next;

  always_comb begin
    level_next = level_reg;
    cnt_next   = '0;
    pulse_next = 1'b0;
    // Any cycle where the synchronized level matches the accepted one
    // restarts the count, which is what rejects short glitches.
    if (sync_reg[1] != level_reg) begin
      if (cnt_reg == CNT_LAST) begin
        level_next = sync_reg[1];
        pulse_next = sync_reg[1];
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg  <= 2'b00;
      level_reg <= 1'b0;
      cnt_reg   <= '0;
      pulse_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], raw};
      level_reg <= level_next;
      cnt_reg   <= cnt_next;
      pulse_reg <= pulse_next;
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch control FSM with button conditioning, second divider, adjust
// blink generator and display scan strobe.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   btn_pause        : raw start/pause button (increment button in ADJUST)
//   btn_reset        : raw clear button
//   sw_adjust        : adjust-mode switch level
//   sw_sel           : adjust field select, 0 = seconds, 1 = minutes
//   count_en         : one-cycle pulse, advance time by one second
//   count_clr        : one-cycle pulse, clear time to 00:00
//   adj_sec_inc      : one-cycle pulse, increment seconds field
//   adj_min_inc      : one-cycle pulse, increment minutes field
//   scan_tick        : one-cycle digit multiplexer strobe
//   blank_mask[3:0]  : per-digit blank, bit0 = sec units .. bit3 = min tens
//   state[1:0]       : current FSM state
module stopwatch_controller
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV        = DEF_TICK_DIV,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int BLINK_DIV       = DEF_BLINK_DIV,
  parameter int SCAN_DIV        = DEF_SCAN_DIV
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_pause,
  input  logic       btn_reset,
  input  logic       sw_adjust,
  input  logic       sw_sel,
  output logic       count_en,
  output logic       count_clr,
  output logic       adj_sec_inc,
  output logic       adj_min_inc,
  output logic       scan_tick,
  output logic [3:0] blank_mask,
  output logic [1:0] state
);

  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);

  // Button conditioning: index 0 = pause, index 1 = reset.
  logic [1:0] btn_raw;
  logic [1:0] btn_pulse;
  logic       pause_pulse;
  logic       reset_pulse;

  assign btn_raw = {btn_reset, btn_pause};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cond (
      .clk  (clk),
      .reset(reset),
      .raw  (btn_raw[gi]),
      .pulse(btn_pulse[gi])
    );
  end

  assign pause_pulse = btn_pulse[0];
  assign reset_pulse = btn_pulse[1];

  state_t              state_reg, state_next;
  logic [TICK_W-1:0]   sec_div_reg, sec_div_next;
  logic [BLINK_W-1:0]  blink_div_reg, blink_div_next;
  logic                blink_phase_reg, blink_phase_next;
  logic [SCAN_W-1:0]   scan_div_reg;
  logic                scan_tick_reg;
  logic                sec_wrap;

  assign sec_wrap = (sec_div_reg == TICK_LAST);

  // The switches are treated as quasi-static levels and used directly.
  // Dividers default to zero so every state except RUN/PAUSE (second
  // divider) and ADJUST (blink) keeps them cleared.
  always_comb begin
    state_next       = state_reg;
    sec_div_next     = '0;
    blink_div_next   = '0;
    blink_phase_next = 1'b0;
    count_en         = 1'b0;
    count_clr        = reset_pulse;
    adj_sec_inc      = 1'b0;
    adj_min_inc      = 1'b0;

    if (reset_pulse) begin
      // Clear wins over everything, including a simultaneous pause press.
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pause_pulse) state_next = sw_adjust ? ADJUST : RUN;
        end
        RUN: begin
          // The divider keeps counting in the cycle a pause is accepted,
          // so a second boundary there still produces count_en.
          count_en     = sec_wrap;
          sec_div_next = sec_wrap ? '0 : sec_div_reg + 1'b1;
          if (pause_pulse) state_next = PAUSE;
        end
        PAUSE: begin
          sec_div_next = sec_div_reg;
          if (pause_pulse) state_next = sw_adjust ? ADJUST : RUN;
        end
        ADJUST: begin
          if (pause_pulse) begin
            adj_min_inc = sw_sel;
            adj_sec_inc = ~sw_sel;
          end
          if (!sw_adjust) begin
            state_next = PAUSE;
          end else if (blink_div_reg == BLINK_LAST) begin
            blink_phase_next = ~blink_phase_reg;
          end else begin
            blink_div_next   = blink_div_reg + 1'b1;
            blink_phase_next = blink_phase_reg;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      sec_div_reg     <= '0;
      blink_div_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      sec_div_reg     <= sec_div_next;
      blink_div_reg   <= blink_div_next;
      blink_phase_reg <= blink_phase_next;
    end
  end

  // Free-running scan strobe; registered so it first fires SCAN_DIV
  // cycles after reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_div_reg  <= '0;
      scan_tick_reg <= 1'b0;
    end else begin
      scan_tick_reg <= (scan_div_reg == SCAN_LAST);
      scan_div_reg  <= (scan_div_reg == SCAN_LAST) ? '0 : scan_div_reg + 1'b1;
    end
  end

  assign scan_tick  = scan_tick_reg;
  assign blank_mask = (state_reg == ADJUST && blink_phase_reg) ? adjust_blank(sw_sel) : 4'b0000;
  assign state      = state_reg;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Self-checking bench for stopwatch_controller with shortened timing
// (TICK_DIV=10, DEBOUNCE_CYCLES=4, BLINK_DIV=6, SCAN_DIV=5).
module tb_stopwatch_controller;

  localparam int TICK_DIV  = 10;
  localparam int DEB       = 4;
  localparam int BLINK_DIV = 6;
  localparam int SCAN_DIV  = 5;

  localparam int S_IDLE   = 0;
  localparam int S_RUN    = 1;
  localparam int S_PAUSE  = 2;
  localparam int S_ADJUST = 3;

  localparam int B_NONE  = 0;
  localparam int B_PAUSE = 1;
  localparam int B_RESET = 2;
  localparam int B_BOTH  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_pause = 1'b0;
  logic       btn_reset = 1'b0;
  logic       sw_adjust = 1'b0;
  logic       sw_sel = 1'b0;
  logic       count_en, count_clr, adj_sec_inc, adj_min_inc, scan_tick;
  logic [3:0] blank_mask;
  logic [1:0] state;

  stopwatch_controller #(
    .TICK_DIV(TICK_DIV),
    .DEBOUNCE_CYCLES(DEB),
    .BLINK_DIV(BLINK_DIV),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_pause(btn_pause),
    .btn_reset(btn_reset),
    .sw_adjust(sw_adjust),
    .sw_sel(sw_sel),
    .count_en(count_en),
    .count_clr(count_clr),
    .adj_sec_inc(adj_sec_inc),
    .adj_min_inc(adj_min_inc),
    .scan_tick(scan_tick),
    .blank_mask(blank_mask),
    .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Pulse / transition accumulators, sampled once per negedge.
  int n_en, n_clr, n_sec, n_min, n_scan, n_trans;
  int n_multi = 0;
  logic [1:0] prev_state = 2'b00;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic clear_counts();
    n_en = 0; n_clr = 0; n_sec = 0; n_min = 0; n_scan = 0; n_trans = 0;
  endtask

  task automatic cyc();
    @(negedge clk);
    n_en   += int'(count_en);
    n_clr  += int'(count_clr);
    n_sec  += int'(adj_sec_inc);
    n_min  += int'(adj_min_inc);
    n_scan += int'(scan_tick);
    if (state != prev_state) n_trans++;
    prev_state = state;
    if (int'(count_en) + int'(adj_sec_inc) + int'(adj_min_inc) > 1) n_multi++;
  endtask

  task automatic press(input int btn, input int hold, input int settle);
    btn_pause = (btn == B_PAUSE || btn == B_BOTH);
    btn_reset = (btn == B_RESET || btn == B_BOTH);
    repeat (hold) cyc();
    btn_pause = 1'b0;
    btn_reset = 1'b0;
    repeat (settle) cyc();
  endtask

  typedef struct {
    int   btn;
    logic adj;
    logic sel;
    int   hold;
    int   exp_state;
    int   exp_clr;
    int   exp_sec;
    int   exp_min;
    int   exp_trans;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_en, bad_state, bad_mask, bad_inc, found, first, st6, st7, exp_mask, exp_min;

    //          btn      adj   sel   hold state     clr sec min trans
    vecs[0]  = '{B_PAUSE, 1'b0, 1'b0, 10, S_RUN,    0, 0, 0, 1};
    vecs[1]  = '{B_PAUSE, 1'b0, 1'b0, 10, S_PAUSE,  0, 0, 0, 1};
    vecs[2]  = '{B_PAUSE, 1'b0, 1'b0, 10, S_RUN,    0, 0, 0, 1};
    vecs[3]  = '{B_PAUSE, 1'b1, 1'b0, 10, S_PAUSE,  0, 0, 0, 1};
    vecs[4]  = '{B_PAUSE, 1'b1, 1'b0, 10, S_ADJUST, 0, 0, 0, 1};
    vecs[5]  = '{B_PAUSE, 1'b1, 1'b0, 10, S_ADJUST, 0, 1, 0, 0};
    vecs[6]  = '{B_PAUSE, 1'b1, 1'b1, 10, S_ADJUST, 0, 0, 1, 0};
    vecs[7]  = '{B_PAUSE, 1'b1, 1'b1, 2,  S_ADJUST, 0, 0, 0, 0};
    vecs[8]  = '{B_RESET, 1'b1, 1'b1, 10, S_IDLE,   1, 0, 0, 1};
    vecs[9]  = '{B_PAUSE, 1'b1, 1'b0, 10, S_ADJUST, 0, 0, 0, 1};
    vecs[10] = '{B_NONE,  1'b0, 1'b0, 10, S_PAUSE,  0, 0, 0, 1};
    vecs[11] = '{B_RESET, 1'b0, 1'b0, 10, S_IDLE,   1, 0, 0, 1};
    vecs[12] = '{B_PAUSE, 1'b0, 1'b0, 10, S_RUN,    0, 0, 0, 1};
    vecs[13] = '{B_BOTH,  1'b0, 1'b0, 10, S_IDLE,   1, 0, 0, 1};
    vecs[14] = '{B_PAUSE, 1'b0, 1'b0, 2,  S_IDLE,   0, 0, 0, 0};
    vecs[15] = '{B_PAUSE, 1'b0, 1'b0, 3,  S_IDLE,   0, 0, 0, 0};
    vecs[16] = '{B_PAUSE, 1'b0, 1'b0, 4,  S_RUN,    0, 0, 0, 1};
    vecs[17] = '{B_RESET, 1'b0, 1'b0, 10, S_IDLE,   1, 0, 0, 1};

    // Power-on reset held for a few cycles.
    clear_counts();
    repeat (3) cyc();
    check("rst_state", int'(state), S_IDLE);
    check("rst_count_en", int'(count_en), 0);
    check("rst_count_clr", int'(count_clr), 0);
    check("rst_adj_sec", int'(adj_sec_inc), 0);
    check("rst_adj_min", int'(adj_min_inc), 0);
    check("rst_scan_tick", n_scan, 0);
    check("rst_blank", int'(blank_mask), 0);
    reset = 1'b0;
    repeat (2) cyc();

    // Transaction table: one button action per row, then settle.
    for (int r = 0; r < NV; r++) begin
      sw_adjust = vecs[r].adj;
      sw_sel    = vecs[r].sel;
      clear_counts();
      press(vecs[r].btn, vecs[r].hold, 14);
      check($sformatf("row%0d_state", r), int'(state), vecs[r].exp_state);
      check($sformatf("row%0d_clr", r), n_clr, vecs[r].exp_clr);
      check($sformatf("row%0d_sec_inc", r), n_sec, vecs[r].exp_sec);
      check($sformatf("row%0d_min_inc", r), n_min, vecs[r].exp_min);
      check($sformatf("row%0d_transitions", r), n_trans, vecs[r].exp_trans);
    end

    // Long press from IDLE: RUN entered 7 cycles after the raw rise,
    // then count_en every 10th cycle starting at cycle 16.
    sw_adjust = 1'b0;
    clear_counts();
    bad_en = 0; bad_state = 0;
    btn_pause = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (i == 20) btn_pause = 1'b0;
      if (int'(count_en) != (((i >= 7) && ((i - 7) % 10 == 9)) ? 1 : 0)) bad_en++;
      if (i >= 7 && int'(state) != S_RUN) bad_state++;
    end
    check("run_en_pattern_errors", bad_en, 0);
    check("run_state_errors", bad_state, 0);
    check("run_en_count", n_en, 3);

    // Pause accepted in the cycle the divider holds 6, then resume.
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      cyc();
      if (count_en) found = 1;
    end
    check("pause_align_en_seen", found, 1);
    cyc();
    btn_pause = 1'b1;
    clear_counts();
    st6 = -1; st7 = -1;
    for (int k = 1; k <= 47; k++) begin
      cyc();
      if (k == 10) btn_pause = 1'b0;
      if (k == 6) st6 = int'(state);
      if (k == 7) st7 = int'(state);
    end
    check("pause_accept_cycle_state", st6, S_RUN);
    check("pause_entered", st7, S_PAUSE);
    check("pause_no_count_en", n_en, 0);
    check("pause_held", int'(state), S_PAUSE);

    btn_pause = 1'b1;
    clear_counts();
    st6 = -1; st7 = -1; first = -1;
    for (int k = 1; k <= 14; k++) begin
      cyc();
      if (k == 10) btn_pause = 1'b0;
      if (k == 6) st6 = int'(state);
      if (k == 7) st7 = int'(state);
      if (count_en && first < 0) first = k;
    end
    check("resume_before_state", st6, S_PAUSE);
    check("resume_state", st7, S_RUN);
    check("resume_first_en_cycle", first, 9);
    check("resume_en_count", n_en, 1);

    clear_counts();
    press(B_RESET, 10, 14);
    check("clear_to_idle", int'(state), S_IDLE);

    // ADJUST on minutes: three increments, blink every 6 cycles.
    sw_adjust = 1'b1;
    sw_sel = 1'b1;
    clear_counts();
    bad_mask = 0; bad_inc = 0; bad_state = 0;
    btn_pause = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      cyc();
      exp_mask = (i >= 7 && ((i - 7) / 6) % 2 == 1) ? 12 : 0;
      exp_min = (i == 26 || i == 46 || i == 66) ? 1 : 0;
      if (int'(blank_mask) != exp_mask) bad_mask++;
      if (int'(adj_min_inc) != exp_min) bad_inc++;
      if (i >= 7 && int'(state) != S_ADJUST) bad_state++;
      btn_pause = (i < 10) || (i >= 20 && i < 30) || (i >= 40 && i < 50) || (i >= 60 && i < 70);
    end
    check("adj_blank_errors", bad_mask, 0);
    check("adj_min_inc_errors", bad_inc, 0);
    check("adj_state_errors", bad_state, 0);
    check("adj_min_inc_count", n_min, 3);
    check("adj_sec_inc_count", n_sec, 0);

    sw_adjust = 1'b0;
    repeat (2) cyc();
    check("adj_exit_state", int'(state), S_PAUSE);
    check("adj_exit_blank", int'(blank_mask), 0);

    // Asynchronous reset in the middle of RUN.
    clear_counts();
    press(B_PAUSE, 10, 14);
    check("pre_reset_state", int'(state), S_RUN);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_state", int'(state), S_IDLE);
    check("async_reset_outputs",
          int'({count_en, count_clr, adj_sec_inc, adj_min_inc, scan_tick, blank_mask}), 0);
    repeat (3) cyc();
    reset = 1'b0;
    clear_counts();
    first = -1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (scan_tick && first < 0) first = k;
    end
    check("scan_first_after_release", first, 5);
    check("scan_count_after_release", n_scan, 2);
    check("release_no_pulses", n_en + n_clr + n_sec + n_min, 0);
    check("release_state", int'(state), S_IDLE);

    check("exclusive_pulse_cycles", n_multi, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
